// File: rtl/camera_pkg.sv
// Shared types for the camera window reader: FSM states, window config, end clipping.
package camera_pkg;

    // Width of the window/counter fields carried in window_cfg_t.
    localparam int CAM_CNT_W = 16;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_FRAME = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [CAM_CNT_W-1:0] x0;
        logic [CAM_CNT_W-1:0] y0;
        logic [CAM_CNT_W-1:0] w;
        logic [CAM_CNT_W-1:0] h;
        logic [1:0]           dx;
        logic [1:0]           dy;
    } window_cfg_t;

    // Exclusive window end (origin + size), computed one bit wider and clipped
    // to the counter maximum so a saturated counter can never fall inside.
    function automatic logic [CAM_CNT_W-1:0] clip_end(input logic [CAM_CNT_W-1:0] org,
                                                      input logic [CAM_CNT_W-1:0] len);
        logic [CAM_CNT_W:0] sum;
        sum = {1'b0, org} + {1'b0, len};
        return sum[CAM_CNT_W] ? {CAM_CNT_W{1'b1}} : sum[CAM_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/isi_sync_frontend.sv
// Sensor pin capture: one register stage, sync polarity normalised to active-high,
// then frame-start (vsync fall) and line-end (hsync fall) edge strobes.
module isi_sync_frontend #(
    parameter int PIX_WIDTH      = 8,
    parameter bit HSYNC_ACT_HIGH = 1'b1,
    parameter bit VSYNC_ACT_HIGH = 1'b1
) (
    input  logic                 pixclk_i,
    input  logic                 rst_n_i,
    input  logic [PIX_WIDTH-1:0] pixel_data_i,
    input  logic                 hsync_i,
    input  logic                 vsync_i,
    output logic [PIX_WIDTH-1:0] pix,
    output logic                 hs_act,
    output logic                 frame_start,
    output logic                 line_end
);

    logic hs_n, vs_n;
    logic hs_q, hs_d, vs_q, vs_d;

    assign hs_n = HSYNC_ACT_HIGH ? hsync_i : ~hsync_i;
    assign vs_n = VSYNC_ACT_HIGH ? vsync_i : ~vsync_i;

    // Capture pins and keep one extra sync stage for edge detection.
    always_ff @(posedge pixclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pix  <= '0;
            hs_q <= 1'b0;
            hs_d <= 1'b0;
            vs_q <= 1'b0;
            vs_d <= 1'b0;
        end else begin
            pix  <= pixel_data_i;
            hs_q <= hs_n;
            hs_d <= hs_q;
            vs_q <= vs_n;
            vs_d <= vs_q;
        end
    end

    assign hs_act      = hs_q;
    assign frame_start = vs_d & ~vs_q;
    assign line_end    = hs_d & ~hs_q;

endmodule

// File: rtl/camera_window_reader.sv
// Camera window reader: row/col tracking, window crop with power-of-2 decimation,
// frame/line markers, line-length checker and FIFO reset hold-off, all on pixclk.
module camera_window_reader
    import camera_pkg::*;
#(
    parameter int PIX_WIDTH      = 8,
    parameter int CNT_WIDTH      = CAM_CNT_W,  // must match CAM_CNT_W (window_cfg_t fields)
    parameter bit HSYNC_ACT_HIGH = 1'b1,
    parameter bit VSYNC_ACT_HIGH = 1'b1,
    parameter int MAX_DEC_LOG2   = 3
) (
    input  logic                 pixclk_i,
    input  logic                 rst_n_i,
    input  logic [PIX_WIDTH-1:0] pixel_data_i,
    input  logic                 hsync_i,
    input  logic                 vsync_i,
    input  logic [CNT_WIDTH-1:0] win_x0_i,
    input  logic [CNT_WIDTH-1:0] win_y0_i,
    input  logic [CNT_WIDTH-1:0] win_w_i,
    input  logic [CNT_WIDTH-1:0] win_h_i,
    input  logic [1:0]           dec_x_log2_i,
    input  logic [1:0]           dec_y_log2_i,
    input  logic                 clr_err_i,
    output logic                 pix_valid_o,
    output logic [PIX_WIDTH-1:0] pix_o,
    output logic [CNT_WIDTH-1:0] row_o,
    output logic [CNT_WIDTH-1:0] col_o,
    output logic                 sof_o,
    output logic                 eol_o,
    output logic [CNT_WIDTH-1:0] frame_cnt_o,
    output logic                 line_err_o,
    output logic                 async_fifo_rst_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [PIX_WIDTH-1:0] fe_pix;
    logic                 fe_hs, frame_start, line_end;

    isi_sync_frontend #(
        .PIX_WIDTH     (PIX_WIDTH),
        .HSYNC_ACT_HIGH(HSYNC_ACT_HIGH),
        .VSYNC_ACT_HIGH(VSYNC_ACT_HIGH)
    ) u_fe (
        .pixclk_i    (pixclk_i),
        .rst_n_i     (rst_n_i),
        .pixel_data_i(pixel_data_i),
        .hsync_i     (hsync_i),
        .vsync_i     (vsync_i),
        .pix         (fe_pix),
        .hs_act      (fe_hs),
        .frame_start (frame_start),
        .line_end    (line_end)
    );

    state_t               state_q, state_d;
    window_cfg_t          cfg_q;
    logic [CNT_WIDTH-1:0] col_q, row_q, len_q;
    logic                 len_vld_q, sof_pend_q;
    logic                 frame_done, err_set, keep, eol_c, win_en, last_row;
    logic [CNT_WIDTH-1:0] x_end, y_end, rel_x, rel_y;
    logic [1:0]           dx_clamp, dy_clamp;

    assign dx_clamp = (int'(dec_x_log2_i) > MAX_DEC_LOG2) ? 2'(MAX_DEC_LOG2) : dec_x_log2_i;
    assign dy_clamp = (int'(dec_y_log2_i) > MAX_DEC_LOG2) ? 2'(MAX_DEC_LOG2) : dec_y_log2_i;

    assign x_end  = clip_end(cfg_q.x0, cfg_q.w);
    assign y_end  = clip_end(cfg_q.y0, cfg_q.h);
    assign rel_x  = col_q - cfg_q.x0;
    assign rel_y  = row_q - cfg_q.y0;
    assign win_en = (cfg_q.w != '0) && (cfg_q.h != '0);

    // Window membership and decimation phase for the pixel currently on the bus.
    always_comb begin
        keep = 1'b0;
        eol_c = 1'b0;
        if (state_q == S_FRAME && !frame_start && fe_hs && win_en
            && col_q >= cfg_q.x0 && col_q < x_end
            && row_q >= cfg_q.y0 && row_q < y_end
            && (rel_x & ~(CNT_MAX << cfg_q.dx)) == '0
            && (rel_y & ~(CNT_MAX << cfg_q.dy)) == '0)
            keep = 1'b1;
        eol_c = ({1'b0, col_q} + ((CNT_WIDTH+1)'(1) << cfg_q.dx)) >= {1'b0, x_end};
    end

    // The line that just ended is the last window row.
    assign last_row = line_end && win_en && (({1'b0, row_q} + (CNT_WIDTH+1)'(1)) == {1'b0, y_end});

    // Frame FSM: a new frame start always (re)opens S_FRAME.
    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        case (state_q)
            S_WAIT:  if (frame_start) state_d = S_FRAME;
            S_FRAME: begin
                if (frame_start) state_d = S_FRAME;
                else if (last_row) begin
                    state_d    = S_DONE;
                    frame_done = 1'b1;
                end
            end
            S_DONE:  if (frame_start) state_d = S_FRAME;
            default: state_d = S_WAIT;
        endcase
    end

    // Any line after the first of a frame whose length differs from it is an error.
    always_comb begin
        err_set = 1'b0;
        if (line_end && !frame_start && state_q != S_WAIT && len_vld_q && col_q != len_q)
            err_set = 1'b1;
    end

    // State, saturating counters, shadow window config and line-length reference.
    always_ff @(posedge pixclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_WAIT;
            col_q     <= '0;
            row_q     <= '0;
            cfg_q     <= '0;
            len_q     <= '0;
            len_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (line_end)                   col_q <= '0;
            else if (fe_hs && col_q != CNT_MAX) col_q <= col_q + 1'b1;
            if (frame_start)                row_q <= '0;
            else if (line_end && row_q != CNT_MAX) row_q <= row_q + 1'b1;
            if (frame_start) begin
                cfg_q     <= '{x0: win_x0_i, y0: win_y0_i, w: win_w_i, h: win_h_i,
                               dx: dx_clamp, dy: dy_clamp};
                len_vld_q <= 1'b0;
            end else if (line_end && state_q != S_WAIT && !len_vld_q) begin
                len_q     <= col_q;
                len_vld_q <= 1'b1;
            end
        end
    end

    // Registered pixel outputs, markers, frame count, sticky error, FIFO reset.
    always_ff @(posedge pixclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pix_valid_o      <= 1'b0;
            pix_o            <= '0;
            row_o            <= '0;
            col_o            <= '0;
            sof_o            <= 1'b0;
            eol_o            <= 1'b0;
            frame_cnt_o      <= '0;
            line_err_o       <= 1'b0;
            async_fifo_rst_o <= 1'b1;
            sof_pend_q       <= 1'b0;
        end else begin
            pix_valid_o <= keep;
            sof_o       <= keep && sof_pend_q;
            eol_o       <= keep && eol_c;
            if (keep) begin
                pix_o <= fe_pix;
                row_o <= rel_y >> cfg_q.dy;
                col_o <= rel_x >> cfg_q.dx;
            end
            if (frame_start)  sof_pend_q <= 1'b1;
            else if (keep)    sof_pend_q <= 1'b0;
            if (frame_done)   frame_cnt_o <= frame_cnt_o + 1'b1;
            if (err_set)      line_err_o <= 1'b1;
            else if (clr_err_i) line_err_o <= 1'b0;
            if (frame_start)  async_fifo_rst_o <= 1'b0;
        end
    end

endmodule
